param_binary_search: RTL



---
 rtl/bsearch_pkg.sv | 22 ++
 rtl/param_binary_search.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the binary-search engine.
package bsearch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    EXACT = 1'b0,
    LOWER = 1'b1
  } mode_t;

  // Midpoint of [lo, hi). The sum is formed in 32 bits so it cannot wrap
  // for any practical address width; callers truncate to ADDR_W+1 bits.
  function automatic logic [31:0] mid_of(input logic [31:0] lo, input logic [31:0] hi);
    return (lo + hi) >> 1;
  endfunction

endpackage

// File: rtl/param_binary_search.sv
// Width/depth-generic binary search over an external 1-cycle synchronous
// sorted memory. Exact mode stops on the first probe that hits; lower-bound
// mode always narrows to lo==hi and reports the insertion point.
// Optional feature macro: BSEARCH_PROBE_CNT_EN (probe counter on `probes`).
import bsearch_pkg::*;

module param_binary_search #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  input  logic              lower_mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              not_found,
  output logic [ADDR_W:0]   index,
  output logic [ADDR_W:0]   probes
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t            state, state_n;
  mode_t             mode_q;
  logic [DATA_W-1:0] key_q;
  logic [ADDR_W:0]   lo, hi, lo_n, hi_n, mid;
  logic [ADDR_W:0]   index_q, index_n;
  logic              hit, hit_n;
  logic              found_q, found_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              latch;

  assign mid      = (ADDR_W+1)'(mid_of(32'(lo), 32'(hi)));
  assign mem_addr = mid[ADDR_W-1:0];

  // Next-state and next-register values for the whole search sequence.
  always_comb begin
    state_n = state;
    lo_n    = lo;
    hi_n    = hi;
    hit_n   = hit;
    index_n = index_q;
    found_n = found_q;
    busy_n  = busy_q;
    done_n  = done_q;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        done_n = 1'b0;
        if (start) begin
          latch   = 1'b1;
          lo_n    = '0;
          hi_n    = DEPTH;
          hit_n   = 1'b0;
          index_n = '0;
          found_n = 1'b0;
          busy_n  = 1'b1;
          state_n = READ;
        end
      end
      READ: state_n = CMP;
      CMP: begin
        if (mode_q == EXACT && mem_rdata == key_q) begin
          index_n = mid;
          found_n = 1'b1;
          state_n = DONE;
        end else begin
          if (mem_rdata < key_q) begin
            lo_n = mid + ONE;
          end else begin
            hi_n  = mid;
            hit_n = (mem_rdata == key_q);
          end
          if (lo_n < hi_n) begin
            state_n = READ;
          end else begin
            index_n = lo_n;
            found_n = (mode_q == LOWER) ? hit_n : 1'b0;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        // First DONE cycle posts the result; afterwards wait for start low
        // so a held start cannot retrigger a search.
        busy_n = 1'b0;
        if (!done_q) begin
          done_n = 1'b1;
        end else if (!start) begin
          done_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Search range and result registers; reset clears any partial result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo      <= '0;
      hi      <= '0;
      hit     <= 1'b0;
      index_q <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lo      <= lo_n;
      hi      <= hi_n;
      hit     <= hit_n;
      index_q <= index_n;
      found_q <= found_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Request operands captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch) begin
      key_q  <= key;
      mode_q <= mode_t'(lower_mode);
    end
  end

`ifdef BSEARCH_PROBE_CNT_EN
  logic [ADDR_W:0] probes_q;

  // Memory reads of the current/last search: cleared on accept, bumped per compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    probes_q <= '0;
    else if (state == IDLE && start) probes_q <= '0;
    else if (state == CMP)           probes_q <= probes_q + ONE;
  end

  assign probes = probes_q;
`else
  assign probes = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign not_found = done_q & ~found_q;
  assign index     = index_q;

endmodule
